// File: rtl/antilog.sv
// Iterative antilog: turns a 3.5 fixed-point log2 code into an unsigned integer ~2^x.
// One constant multiply per fraction bit (MSB first), then a single shift by the integer part.
module antilog #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FRAC_W     = 5
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] log_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] number_o
);

    localparam int unsigned IntW = DATA_WIDTH - FRAC_W;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StMul   = 2'd1;
    localparam logic [1:0] StScale = 2'd2;
    localparam logic [1:0] StHold  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [IntW-1:0]       e_q, e_d;
    logic [FRAC_W-1:0]     c_q, c_d;
    logic [5:0]            m_q, m_d;
    logic [2:0]            k_q, k_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] number_q, number_d;
    logic [5:0]            k_const;

    // Q.5 roots of two, indexed by fraction bit: 2^(2^(k-5))
    always_comb begin
        k_const = 6'd33;
        case (k_q)
            3'd4:    k_const = 6'd45;
            3'd3:    k_const = 6'd38;
            3'd2:    k_const = 6'd35;
            default: k_const = 6'd33;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        c_d      = c_q;
        m_d      = m_q;
        k_d      = k_q;
        valid_d  = valid_q;
        number_d = number_q;
        case (state_q)
            StIdle: begin
                if (valid_i) begin
                    e_d     = log_i[DATA_WIDTH-1:FRAC_W];
                    c_d     = log_i[FRAC_W-1:0];
                    m_d     = 6'd32;
                    k_d     = 3'd4;
                    state_d = StMul;
                end
            end
            StMul: begin
                if (c_q[k_q]) begin
                    m_d = 6'(({6'b0, m_q} * {6'b0, k_const}) >> 5);
                end
                if (k_q == 3'd0) begin
                    state_d = StScale;
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            StScale: begin
                // m peaks at 59, so 59 << 7 still fits the 13-bit intermediate
                number_d = DATA_WIDTH'(({7'b0, m_q} << e_q) >> 5);
                valid_d  = 1'b1;
                state_d  = StHold;
            end
            StHold: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= StIdle;
            e_q      <= '0;
            c_q      <= '0;
            m_q      <= '0;
            k_q      <= '0;
            valid_q  <= 1'b0;
            number_q <= '0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            c_q      <= c_d;
            m_q      <= m_d;
            k_q      <= k_d;
            valid_q  <= valid_d;
            number_q <= number_d;
        end
    end

    assign ready_o  = rstn_i && (state_q == StIdle);
    assign valid_o  = valid_q;
    assign number_o = number_q;

endmodule

// File: tb/tb_antilog.sv
// Scoreboard bench for antilog: stimulus pushes hand-computed results, a negedge monitor
// pops and checks value and accept-to-valid latency on each new result.
module tb_antilog;

    logic       clk_i;
    logic       rstn_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] log_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] number_o;

    antilog dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .log_i    (log_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .number_o (number_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int val;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    int   last_acc = 0;
    logic valid_prev = 1'b0;

    always @(posedge clk_i) edge_cnt = edge_cnt + 1;

    task automatic check(input string name, input int act, input int req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: one comparison set per rising valid_o
    always @(negedge clk_i) begin
        if (valid_o === 1'b1 && valid_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("number_o", int'(number_o), e.val);
                check("latency", edge_cnt - e.acc, 6);
            end
        end
        valid_prev = valid_o;
    end

    // Called at a negedge; waits for ready_o, then presents code for one edge.
    task automatic send(input logic [7:0] code, input int val);
        int n;
        n = 0;
        while (ready_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (ready_o !== 1'b1) begin
            check("ready_timeout", 0, 1);
        end else begin
            exp_t e;
            valid_i  = 1'b1;
            log_i    = code;
            e.val    = val;
            e.acc    = edge_cnt + 1;
            last_acc = e.acc;
            exp_q.push_back(e);
            @(negedge clk_i);
            valid_i = 1'b0;
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (valid_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (valid_o !== 1'b1) check("valid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ready_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (ready_o !== 1'b1) check("idle_timeout", 0, 1);
    endtask

    initial begin
        int acc_a;
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        log_i   = 8'h00;
        ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_ready_o", int'(ready_o), 0);
        check("rst_valid_o", int'(valid_o), 0);
        check("rst_number_o", int'(number_o), 0);
        rstn_i = 1'b1;
        #1;
        check("idle_ready_o", int'(ready_o), 1);

        // Basic vectors; back-to-back accepts must be 8 edges apart
        send(8'h60, 8);
        acc_a = last_acc;
        send(8'hB0, 45);
        check("accept_spacing", last_acc - acc_a, 8);
        send(8'h10, 1);
        send(8'hFF, 236);
        send(8'h00, 1);
        wait_valid();
        wait_idle();

        // Stall in HOLD; extra valid_i during MUL/HOLD must be ignored
        @(negedge clk_i);
        ready_i = 1'b0;
        send(8'hFF, 236);
        check("busy_ready_o", int'(ready_o), 0);
        valid_i = 1'b1;
        log_i   = 8'h60;
        repeat (3) @(negedge clk_i);
        wait_valid();
        log_i = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("hold_valid_o", int'(valid_o), 1);
            check("hold_number_o", int'(number_o), 236);
            check("hold_ready_o", int'(ready_o), 0);
        end
        valid_i = 1'b0;
        @(negedge clk_i);
        ready_i = 1'b1;
        @(negedge clk_i);
        check("release_valid_o", int'(valid_o), 0);
        check("retain_number_o", int'(number_o), 236);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("no_capture_valid_o", int'(valid_o), 0);
            check("no_capture_ready_o", int'(ready_o), 1);
        end

        // Reset during MUL drops the in-flight code
        send(8'h60, 8);
        @(negedge clk_i);
        rstn_i = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk_i);
        check("midrst_ready_o", int'(ready_o), 0);
        check("midrst_valid_o", int'(valid_o), 0);
        check("midrst_number_o", int'(number_o), 0);
        rstn_i = 1'b1;
        #1;
        check("postrst_ready_o", int'(ready_o), 1);
        @(negedge clk_i);
        send(8'h60, 8);
        wait_valid();
        wait_idle();
        repeat (3) @(negedge clk_i);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
